// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler for two SPI requesters: sequences multi-byte bursts as
// single-byte spi_master transactions and generates the divided SCLK.
module spi_xfer_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 8,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            req,
    input  logic [LEN_W-1:0]      req_len0,
    input  logic [LEN_W-1:0]      req_len1,
    input  logic [1:0]            req_cpol,
    input  logic [1:0]            req_cpha,
    input  logic [DATA_WIDTH-1:0] tx_data0,
    input  logic [DATA_WIDTH-1:0] tx_data1,
    input  logic [1:0]            tx_valid,
    output logic [1:0]            tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [1:0]            rx_valid,
    output logic [1:0]            grant,
    output logic [1:0]            xfer_done,
    output logic                  busy,
    output logic                  m_start,
    output logic [DATA_WIDTH-1:0] m_tx_data,
    output logic                  m_cpol,
    output logic                  m_cpha,
    input  logic                  m_done,
    input  logic [DATA_WIDTH-1:0] m_rx_data,
    input  logic                  m_sclk_enable,
    output logic                  sclk
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_FETCH = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t                  state_r;
    logic                    last_r;
    logic                    win_r;
    logic [LEN_W-1:0]        remaining_r;
    logic [GAP_W-1:0]        gap_cnt_r;
    logic [DIV_W-1:0]        div_r;
    logic [1:0]              grant_r;
    logic [1:0]              tx_ready_r;
    logic [1:0]              rx_valid_r;
    logic [1:0]              xfer_done_r;
    logic                    busy_r;
    logic                    m_start_r;
    logic [DATA_WIDTH-1:0]   m_tx_data_r;
    logic [DATA_WIDTH-1:0]   rx_data_r;
    logic                    m_cpol_r;
    logic                    m_cpha_r;
    logic                    sclk_r;

    logic                    win_s;
    logic [1:0]              win_oh_s;
    logic [LEN_W-1:0]        req_len_s;
    logic [DATA_WIDTH-1:0]   tx_data_s;
    logic                    tx_valid_s;

    // Arbitration: a lone requester wins, contention goes to the one not served last
    always_comb begin
        win_s = 1'b0;
        case (req)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_r;
            default: win_s = 1'b0;
        endcase
    end

    assign win_oh_s   = win_s ? 2'b10 : 2'b01;
    assign req_len_s  = win_s ? req_len1 : req_len0;
    assign tx_data_s  = win_r ? tx_data1 : tx_data0;
    assign tx_valid_s = win_r ? tx_valid[1] : tx_valid[0];

    // Burst sequencer; grant and per-burst mode are captured as GRANT is entered
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            win_r       <= 1'b0;
            remaining_r <= {LEN_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            grant_r     <= 2'b00;
            tx_ready_r  <= 2'b00;
            rx_valid_r  <= 2'b00;
            xfer_done_r <= 2'b00;
            busy_r      <= 1'b0;
            m_start_r   <= 1'b0;
            m_tx_data_r <= {DATA_WIDTH{1'b0}};
            rx_data_r   <= {DATA_WIDTH{1'b0}};
            m_cpol_r    <= 1'b0;
            m_cpha_r    <= 1'b0;
        end else begin
            tx_ready_r  <= 2'b00;
            rx_valid_r  <= 2'b00;
            xfer_done_r <= 2'b00;
            m_start_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant_r     <= win_oh_s;
                        win_r       <= win_s;
                        last_r      <= win_s;
                        remaining_r <= req_len_s;
                        m_cpol_r    <= req_cpol[win_s];
                        m_cpha_r    <= req_cpha[win_s];
                        busy_r      <= 1'b1;
                        state_r     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (remaining_r == {LEN_W{1'b0}}) begin
                        xfer_done_r <= grant_r;
                        grant_r     <= 2'b00;
                        gap_cnt_r   <= {GAP_W{1'b0}};
                        state_r     <= ST_GAP;
                    end else begin
                        state_r     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (tx_valid_s) begin
                        tx_ready_r  <= grant_r;
                        m_tx_data_r <= tx_data_s;
                        m_start_r   <= 1'b1;
                        state_r     <= ST_START;
                    end
                end
                ST_START: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        rx_data_r   <= m_rx_data;
                        rx_valid_r  <= grant_r;
                        remaining_r <= remaining_r - LEN_W'(1);
                        if (remaining_r == LEN_W'(1)) begin
                            xfer_done_r <= grant_r;
                            grant_r     <= 2'b00;
                            gap_cnt_r   <= {GAP_W{1'b0}};
                            state_r     <= ST_GAP;
                        end else begin
                            state_r     <= ST_FETCH;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    grant_r <= 2'b00;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // SCLK divider: parks at CPOL while spi_master is idle, toggles every CLK_DIV clocks
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_r <= 1'b0;
            div_r  <= {DIV_W{1'b0}};
        end else if (!m_sclk_enable) begin
            sclk_r <= m_cpol_r;
            div_r  <= {DIV_W{1'b0}};
        end else if (div_r == DIV_W'(CLK_DIV - 1)) begin
            sclk_r <= ~sclk_r;
            div_r  <= {DIV_W{1'b0}};
        end else begin
            div_r  <= div_r + DIV_W'(1);
        end
    end

    assign grant     = grant_r;
    assign tx_ready  = tx_ready_r;
    assign rx_valid  = rx_valid_r;
    assign xfer_done = xfer_done_r;
    assign busy      = busy_r;
    assign m_start   = m_start_r;
    assign m_tx_data = m_tx_data_r;
    assign rx_data   = rx_data_r;
    assign m_cpol    = m_cpol_r;
    assign m_cpha    = m_cpha_r;
    assign sclk      = sclk_r;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with a behavioural spi_master and byte suppliers.
module tb_spi_xfer_sched;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] req;
    logic [7:0] req_len0, req_len1;
    logic [1:0] req_cpol, req_cpha;
    logic [7:0] tx_data0 = 8'h00;
    logic [7:0] tx_data1 = 8'h00;
    logic [1:0] tx_valid;
    logic [1:0] tx_ready, rx_valid, grant, xfer_done;
    logic [7:0] rx_data, m_tx_data;
    logic       busy, m_start, m_cpol, m_cpha, sclk;
    logic       m_done = 1'b0;
    logic [7:0] m_rx_data = 8'h00;
    logic       m_sclk_enable = 1'b0;

    always #5 clk = ~clk;

    spi_xfer_sched #(.DATA_WIDTH(8), .LEN_W(8), .CLK_DIV(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_len0(req_len0), .req_len1(req_len1),
        .req_cpol(req_cpol), .req_cpha(req_cpha), .tx_data0(tx_data0), .tx_data1(tx_data1),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .grant(grant), .xfer_done(xfer_done), .busy(busy), .m_start(m_start),
        .m_tx_data(m_tx_data), .m_cpol(m_cpol), .m_cpha(m_cpha), .m_done(m_done),
        .m_rx_data(m_rx_data), .m_sclk_enable(m_sclk_enable), .sclk(sclk)
    );

    int vectors = 0;
    int miscompares = 0;

    int         cyc = 0;
    logic       en_m = 1'b0;
    int         edges = 0;
    logic       prev_sclk = 1'b0;
    logic [7:0] cap_tx = 8'h00;
    logic       use_pat = 1'b0;
    int         xd_cnt[2] = '{0, 0};
    int         rxv_cnt[2] = '{0, 0};
    int         mstart_cnt = 0, viol_cnt = 0, rise_cnt = 0, gapbusy_cnt = 0;
    int         last_period = 0, last_rise_cyc = -1, grant_cyc = 0, xd_cyc = 0;
    logic       sclk_at_start = 1'b0;
    logic [7:0] rx_log[256];
    int         rx_n = 0;
    logic [1:0] g_log[64];
    int         g_n = 0;
    logic [1:0] prev_grant = 2'b00;
    logic [7:0] tab0[256];
    logic [7:0] tab1[256];
    int         idx0 = 0, idx1 = 0;

    // Monitors, byte suppliers and spi_master model, all evaluated away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (rx_valid[0]) rxv_cnt[0]++;
        if (rx_valid[1]) rxv_cnt[1]++;
        if (rx_valid != 2'b00) begin
            rx_log[rx_n % 256] = rx_data;
            rx_n++;
        end
        if (xfer_done[0]) begin xd_cnt[0]++; xd_cyc = cyc; end
        if (xfer_done[1]) begin xd_cnt[1]++; xd_cyc = cyc; end
        if (grant != prev_grant && grant != 2'b00) begin
            g_log[g_n % 64] = grant;
            g_n++;
            grant_cyc = cyc;
        end
        prev_grant = grant;
        if (m_start) begin
            mstart_cnt++;
            sclk_at_start = sclk;
            if (en_m) viol_cnt++;
        end
        if (busy && grant == 2'b00) gapbusy_cnt++;
        if (en_m && sclk && !prev_sclk) begin
            if (last_rise_cyc >= 0) last_period = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
            rise_cnt++;
        end
        if (tx_ready[0]) idx0++;
        if (tx_ready[1]) idx1++;
        tx_data0 = tab0[idx0 % 256];
        tx_data1 = tab1[idx1 % 256];
        m_done = 1'b0;
        if (!resetn) begin
            en_m  = 1'b0;
            edges = 0;
        end else if (en_m) begin
            if (sclk != prev_sclk) edges++;
            if (edges == 16) begin
                en_m      = 1'b0;
                m_done    = 1'b1;
                m_rx_data = use_pat ? 8'h5A : cap_tx;
            end
        end else if (m_start) begin
            en_m          = 1'b1;
            edges         = 0;
            cap_tx        = m_tx_data;
            last_rise_cyc = -1;
        end
        m_sclk_enable = en_m;
        prev_sclk     = sclk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int get_cnt(input int sel);
        case (sel)
            0:       return xd_cnt[0];
            1:       return xd_cnt[1];
            2:       return xd_cnt[0] + xd_cnt[1];
            3:       return rx_n;
            4:       return int'(en_m);
            default: return 0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int target, input int limit, input string tag);
        int n = 0;
        while (get_cnt(sel) < target && n < limit) begin
            tick(1);
            n++;
        end
        check_val(tag, (get_cnt(sel) >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rx, b_xd, b_rise, b_ms, b_gb, b_rxv0, b_rxv1, b_g, b_xd1, bad;
        req = 2'b00; req_len0 = 8'd0; req_len1 = 8'd0;
        req_cpol = 2'b00; req_cpha = 2'b00; tx_valid = 2'b00; resetn = 1'b0;
        tick(3);
        check_val("rst_grant", grant, 32'd0);
        check_val("rst_busy", busy, 32'd0);
        check_val("rst_sclk", sclk, 32'd0);
        check_val("rst_mstart", m_start, 32'd0);
        check_val("rst_cpol", m_cpol, 32'd0);
        resetn = 1'b1;
        tick(1);

        // single 3-byte burst, mode 0, loopback
        tab0[idx0 % 256] = 8'hA5; tab0[(idx0 + 1) % 256] = 8'h3C; tab0[(idx0 + 2) % 256] = 8'hFF;
        b_rx = rx_n; b_xd = xd_cnt[0]; b_rise = rise_cnt; b_rxv0 = rxv_cnt[0]; b_xd1 = xd_cnt[1];
        req_len0 = 8'd3; tx_valid = 2'b11; req = 2'b01;
        wait_for(0, b_xd + 1, 600, "t1_done");
        req = 2'b00;
        check_val("t1_rxv_cnt", rxv_cnt[0] - b_rxv0, 32'd3);
        check_val("t1_rx0", rx_log[b_rx % 256], 32'hA5);
        check_val("t1_rx1", rx_log[(b_rx + 1) % 256], 32'h3C);
        check_val("t1_rx2", rx_log[(b_rx + 2) % 256], 32'hFF);
        check_val("t1_xd1_none", xd_cnt[1] - b_xd1, 32'd0);
        check_val("t1_rises", rise_cnt - b_rise, 32'd24);
        check_val("t1_period", last_period, 32'd8);
        tick(4);
        check_val("t1_xd_once", xd_cnt[0] - b_xd, 32'd1);

        // contention from reset: round-robin alternation
        resetn = 1'b0; tick(1); resetn = 1'b1; tick(1);
        b_g = g_n; b_xd = get_cnt(2);
        req_len0 = 8'd1; req_len1 = 8'd1; req = 2'b11;
        wait_for(2, b_xd + 4, 1200, "t2_done");
        req = 2'b00;
        check_val("t2_g0", g_log[b_g % 64], 32'd1);
        check_val("t2_g1", g_log[(b_g + 1) % 64], 32'd2);
        check_val("t2_g2", g_log[(b_g + 2) % 64], 32'd1);
        check_val("t2_g3", g_log[(b_g + 3) % 64], 32'd2);
        tick(4);

        // mode 3 single byte on requester 1, slave answers 0x5A
        use_pat = 1'b1;
        b_rise = rise_cnt; b_rx = rx_n; b_rxv0 = rxv_cnt[0]; b_rxv1 = rxv_cnt[1]; b_xd = xd_cnt[1];
        req_len1 = 8'd1; req_cpol = 2'b10; req_cpha = 2'b10; req = 2'b10;
        wait_for(1, b_xd + 1, 400, "t3_done");
        req = 2'b00;
        check_val("t3_cpol", m_cpol, 32'd1);
        check_val("t3_cpha", m_cpha, 32'd1);
        check_val("t3_sclk_idle_hi", sclk_at_start, 32'd1);
        check_val("t3_rises", rise_cnt - b_rise, 32'd8);
        check_val("t3_rx", rx_log[b_rx % 256], 32'h5A);
        check_val("t3_rxv1", rxv_cnt[1] - b_rxv1, 32'd1);
        check_val("t3_rxv0_none", rxv_cnt[0] - b_rxv0, 32'd0);
        tick(4);
        check_val("t3_sclk_after", sclk, 32'd1);
        use_pat = 1'b0;

        // zero-length burst
        b_ms = mstart_cnt; b_gb = gapbusy_cnt; b_xd = xd_cnt[0]; b_rxv0 = rxv_cnt[0];
        req_cpol = 2'b00; req_cpha = 2'b00; req_len0 = 8'd0; req = 2'b01;
        wait_for(0, b_xd + 1, 50, "t4_done");
        req = 2'b00;
        tick(4);
        check_val("t4_xd_latency", xd_cyc - grant_cyc, 32'd1);
        check_val("t4_no_start", mstart_cnt - b_ms, 32'd0);
        check_val("t4_gap_busy", gapbusy_cnt - b_gb, 32'd2);
        check_val("t4_no_rx", rxv_cnt[0] - b_rxv0, 32'd0);
        check_val("t4_xd_once", xd_cnt[0] - b_xd, 32'd1);

        // TX stall mid-burst
        tab0[idx0 % 256] = 8'h11; tab0[(idx0 + 1) % 256] = 8'h22; tab0[(idx0 + 2) % 256] = 8'h33;
        b_rx = rx_n; b_xd = xd_cnt[0];
        req_len0 = 8'd3; tx_valid = 2'b11; req = 2'b01;
        wait_for(3, b_rx + 1, 300, "t5_first_byte");
        tx_valid = 2'b10;
        b_ms = mstart_cnt; bad = 0;
        repeat (20) begin
            tick(1);
            if (grant != 2'b01 || sclk != 1'b0) bad++;
        end
        check_val("t5_stall_hold", bad, 32'd0);
        check_val("t5_stall_nostart", mstart_cnt - b_ms, 32'd0);
        tx_valid = 2'b11;
        wait_for(0, b_xd + 1, 400, "t5_done");
        req = 2'b00;
        check_val("t5_rx0", rx_log[b_rx % 256], 32'h11);
        check_val("t5_rx1", rx_log[(b_rx + 1) % 256], 32'h22);
        check_val("t5_rx2", rx_log[(b_rx + 2) % 256], 32'h33);
        tick(4);

        // reset during byte 2 of 4 (CPOL=1 so the mode register reset is visible)
        tab0[idx0 % 256] = 8'h81; tab0[(idx0 + 1) % 256] = 8'h42;
        tab0[(idx0 + 2) % 256] = 8'h24; tab0[(idx0 + 3) % 256] = 8'h18;
        b_rx = rx_n; b_xd = get_cnt(2);
        req_cpol = 2'b01; req_len0 = 8'd4; req = 2'b01;
        wait_for(3, b_rx + 1, 300, "t6_first_byte");
        wait_for(4, 1, 20, "t6_byte2_active");
        resetn = 1'b0; req = 2'b00;
        tick(1);
        check_val("t6_grant", grant, 32'd0);
        check_val("t6_busy", busy, 32'd0);
        check_val("t6_sclk", sclk, 32'd0);
        check_val("t6_cpol", m_cpol, 32'd0);
        check_val("t6_mtx", m_tx_data, 32'd0);
        check_val("t6_rxd", rx_data, 32'd0);
        check_val("t6_xd_now", xfer_done, 32'd0);
        check_val("t6_mstart", m_start, 32'd0);
        tick(1);
        resetn = 1'b1; req_cpol = 2'b00;
        tick(2);
        check_val("t6_no_xd", get_cnt(2) - b_xd, 32'd0);
        b_g = g_n; b_xd = xd_cnt[0];
        req_len0 = 8'd1; req_len1 = 8'd1; req = 2'b11;
        wait_for(0, b_xd + 1, 300, "t6_restart_done");
        req = 2'b00;
        check_val("t6_first_winner", g_log[b_g % 64], 32'd1);
        tick(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
